// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if -- handshake bundle around the instruction fetch queue.
//   ireq_*   : fetch requests to instruction memory (valid/ready, word address)
//   iresp_*  : in-order responses from instruction memory
//   instr_*  : head of the instruction queue toward the core (valid/ready)
//   redirect*: control-flow change, flushes the fetch stream
// master = the fetch queue, slave = memory/core side.
interface ifetch_queue_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output ireq_valid, ireq_addr, instr_valid, instr, instr_pc,
        input  ireq_ready, iresp_valid, iresp_data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, instr_valid, instr, instr_pc,
        output ireq_ready, iresp_valid, iresp_data, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction prefetch queue.
// Issues sequential word fetches, stores in-order responses with their PC and
// presents the oldest one to the core. A redirect flushes the queue, reloads
// the fetch PC and marks all in-flight responses as stale so they get dropped.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : ifetch_queue_if.master (ireq_*, iresp_*, instr_*, redirect*)
// Parameters: DEPTH (entries + outstanding fetches, power of two 2..16),
//             RESET_PC (first fetch address).
// Option: define IFQ_BYPASS_EN to forward a response straight to instr_* when
//         the queue is empty (same-cycle delivery). Default build has no
//         combinational path from iresp_* to instr_*.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;       // next fetch address
    logic [31:0]   rpc_q, rpc_d;     // PC of the next non-stale response
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] stale_q, stale_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   ipc_q  [DEPTH];

    logic          acc, rsp, keep, push, pop;
    logic [CW:0]   inflight;

    assign inflight       = {1'b0, occ_q} + {1'b0, out_q};
    // Queued entries plus outstanding fetches never exceed DEPTH, so a
    // response always finds a free slot.
    assign bus.ireq_valid = reset && !bus.redirect && (inflight < (CW+1)'(DEPTH));
    assign bus.ireq_addr  = pc_q;
    assign acc            = bus.ireq_valid && bus.ireq_ready;

    // A response with nothing outstanding (e.g. one in flight across a reset)
    // has no owner and is ignored.
    assign rsp  = bus.iresp_valid && (out_q != '0);
    assign keep = rsp && !bus.redirect && (stale_q == '0);
    assign pop  = (occ_q != '0) && bus.instr_ready && !bus.redirect;

`ifdef IFQ_BYPASS_EN
    logic byp;
    assign byp             = keep && (occ_q == '0);
    // A bypassed response taken by the core this cycle is never stored.
    assign push            = keep && !(byp && bus.instr_ready);
    assign bus.instr_valid = (occ_q != '0) || byp;
    assign bus.instr       = (occ_q != '0) ? data_q[rd_q] : (byp ? bus.iresp_data : '0);
    assign bus.instr_pc    = (occ_q != '0) ? ipc_q[rd_q]  : (byp ? rpc_q : '0);
`else
    assign push            = keep;
    assign bus.instr_valid = (occ_q != '0);
    assign bus.instr       = (occ_q != '0) ? data_q[rd_q] : '0;
    assign bus.instr_pc    = (occ_q != '0) ? ipc_q[rd_q]  : '0;
`endif

    always_comb begin
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        out_d   = out_q;
        stale_d = stale_q;
        occ_d   = occ_q;
        if (acc) pc_d = pc_q + 32'd4;
        case ({acc, rsp})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: ;
        endcase
        if (keep) rpc_d = rpc_q + 32'd4;
        if (rsp && !bus.redirect && (stale_q != '0)) stale_d = stale_q - CW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: ;
        endcase
        // Redirect wins over pop and response; everything still in flight
        // after this cycle's response belongs to the old stream.
        if (bus.redirect) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            rpc_d   = {bus.redirect_pc[31:2], 2'b00};
            stale_d = out_d;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            rpc_q   <= RESET_PC;
            occ_q   <= '0;
            out_q   <= '0;
            stale_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            occ_q   <= occ_d;
            out_q   <= out_d;
            stale_q <= stale_d;
            if (bus.redirect) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    data_q[wr_q] <= bus.iresp_data;
                    ipc_q[wr_q]  <= rpc_q;
                    wr_q         <= wr_q + AW'(1);
                end
                if (pop) rd_q <= rd_q + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4, RESET_PC=0). The memory model
// answers every accepted fetch with data = addr + 0x13 after 'lat' cycles.
module tb_ifetch_queue;
`ifdef IFQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t inflight[$];
    int   cyc, lat, nacc;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle: record this cycle's acceptance, cross the edge,
    // then present the response due in the new cycle.
    task automatic tick();
        rsp_t r;
        #1;
        if (bus.ireq_valid && bus.ireq_ready) begin
            r.addr = bus.ireq_addr;
            r.due  = cyc + lat;
            inflight.push_back(r);
            nacc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.iresp_valid = 1'b0;
        bus.iresp_data  = '0;
        if (inflight.size() != 0 && inflight[0].due <= cyc) begin
            r = inflight.pop_front();
            bus.iresp_valid = 1'b1;
            bus.iresp_data  = r.addr + 32'h13;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.iresp_valid = 1'b0;
        bus.iresp_data  = '0;
        inflight.delete();
        @(posedge clk);
        #1;
        chk({tag, "_ireq_valid"},  {31'b0, bus.ireq_valid},  32'h0);
        chk({tag, "_ireq_addr"},   bus.ireq_addr,             32'h0);
        chk({tag, "_instr_valid"}, {31'b0, bus.instr_valid}, 32'h0);
        chk({tag, "_instr"},       bus.instr,                 32'h0);
        chk({tag, "_instr_pc"},    bus.instr_pc,              32'h0);
        reset = 1'b1;
        cyc   = 0;
        nacc  = 0;
        #1;
    endtask

    initial begin
        bus.ireq_ready  = 1'b1;
        bus.iresp_valid = 1'b0;
        bus.iresp_data  = '0;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Streaming: latency 1, core always ready.
        lat = 1;
        bus.instr_ready = 1'b1;
        do_reset("rst");
        chk("first_req_valid", {31'b0, bus.ireq_valid}, 32'h1);
        chk("first_req_addr", bus.ireq_addr, 32'h0);
        tick();
        chk("c1_addr", bus.ireq_addr, 32'h4);
        chk("c1_instr_valid", {31'b0, bus.instr_valid}, 32'(BYP));
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("stream_addr", bus.ireq_addr, 32'(k * 4));
            chk("stream_valid", {31'b0, bus.instr_valid}, 32'h1);
            chk("stream_pc", bus.instr_pc, 32'((k - 2 + BYP) * 4));
            chk("stream_instr", bus.instr, 32'((k - 2 + BYP) * 4 + 'h13));
        end

        // Core stalled: exactly DEPTH fetches, then resume at 0x10.
        bus.instr_ready = 1'b0;
        do_reset("rst2");
        for (int k = 0; k < 8; k++) tick();
        chk("stall_nacc", 32'(nacc), 32'd4);
        chk("stall_req_valid", {31'b0, bus.ireq_valid}, 32'h0);
        chk("stall_head_pc", bus.instr_pc, 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        chk("resume_valid", {31'b0, bus.ireq_valid}, 32'h1);
        chk("resume_addr", bus.ireq_addr, 32'h10);
        chk("resume_head_pc", bus.instr_pc, 32'h4);

        // Redirect to 0x103 with two fetches outstanding (latency 3).
        lat = 3;
        bus.instr_ready = 1'b0;
        do_reset("rst3");
        tick();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_no_req", {31'b0, bus.ireq_valid}, 32'h0);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("redir_addr", bus.ireq_addr, 32'h100);
        chk("redir_req_valid", {31'b0, bus.ireq_valid}, 32'h1);
        tick();
        chk("stale_drop1", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        chk("stale_drop2", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        tick();
        chk("redir_first_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("redir_first_pc", bus.instr_pc, 32'h100);
        chk("redir_first_instr", bus.instr, 32'h113);

        // Redirect coincident with response and pop (latency 2).
        lat = 2;
        bus.instr_ready = 1'b1;
        do_reset("rst4");
        tick();
        tick();
        tick();
        chk("coinc_rsp_present", {31'b0, bus.iresp_valid}, 32'h1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        chk("coinc_empty", {31'b0, bus.instr_valid}, 32'h0);
        chk("coinc_addr", bus.ireq_addr, 32'h200);
        tick();
        chk("coinc_stale_drop", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        tick();
        chk("coinc_first_pc", bus.instr_pc, 32'h200);
        chk("coinc_first_instr", bus.instr, 32'h213);

        // Address wrap at the top of memory; low redirect bits are ignored.
        lat = 1;
        bus.instr_ready = 1'b0;
        do_reset("rst5");
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("wrap_no_req", {31'b0, bus.ireq_valid}, 32'h0);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("wrap_top_addr", bus.ireq_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero_addr", bus.ireq_addr, 32'h0);
        tick();
        chk("wrap_head_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_head_instr", bus.instr, 32'h0000_000F);
        bus.instr_ready = 1'b1;
        tick();
        chk("wrap_next_pc", bus.instr_pc, 32'h0);
        chk("wrap_next_instr", bus.instr, 32'h13);

        // Back-to-back redirects: only the last target is fetched.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        tick();
        bus.redirect_pc = 32'h0000_0404;
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("dbl_redir_addr", bus.ireq_addr, 32'h404);
        for (int k = 0; k < 20; k++) begin
            if (bus.instr_valid) break;
            tick();
        end
        chk("dbl_redir_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("dbl_redir_pc", bus.instr_pc, 32'h404);

        // Asynchronous reset in the middle of a cycle with data queued.
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_valid", {31'b0, bus.instr_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("async_rst_req", {31'b0, bus.ireq_valid}, 32'h0);
        chk("async_rst_addr", bus.ireq_addr, 32'h0);
        chk("async_rst_pc", bus.instr_pc, 32'h0);
        do_reset("rst6");
        chk("post_rst_addr", bus.ireq_addr, 32'h0);
        chk("post_rst_req", {31'b0, bus.ireq_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries plus outstanding fetches, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ireq_valid  output  1  fetch request to instruction memory.
REQ-006 ireq_addr  output  32  fetch address, word aligned.
REQ-007 ireq_ready  input  1  memory accepts request when ireq_valid && ireq_ready.
REQ-008 iresp_valid  input  1  in-order response, latency >= 1 cycle after acceptance.
REQ-009 iresp_data  input  32  returned instruction word.
REQ-010 instr_valid  output  1  queue head holds a valid instruction for the core.
REQ-011 instr  output  32  head instruction word.
REQ-012 instr_pc  output  32  address of head instruction.
REQ-013 instr_ready  input  1  core consumes head when instr_valid && instr_ready.
REQ-014 redirect  input  1  branch/jump taken, flush the fetch stream.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.

Function
REQ-016 Fetch PC register SHALL drive ireq_addr; it SHALL advance by 4 on each accepted request, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 ireq_valid SHALL be 1 only when !redirect and (occupancy + outstanding) < DEPTH.
REQ-018 outstanding SHALL increment on request acceptance, decrement on iresp_valid, both in one cycle leaving it unchanged.
REQ-019 Non-stale responses SHALL be written to the queue tail with their PC; the queue SHALL never overflow by construction of REQ-017.
REQ-020 instr_valid SHALL equal (occupancy != 0); the head SHALL pop on instr_valid && instr_ready; push and pop in one cycle SHALL keep occupancy unchanged.
REQ-021 Queue pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be clog2(DEPTH)+1 bits wide.
REQ-022 On redirect: the queue SHALL be emptied the next cycle, fetch PC loaded with {redirect_pc[31:2],2'b00}, no request issued that cycle, and stale loaded with the outstanding count after this cycle's response.
REQ-023 While stale > 0, each iresp_valid SHALL be discarded and decrement stale; redirect during a stale period SHALL reload stale per REQ-022.
REQ-024 Redirect coincident with a core pop or with iresp_valid: redirect SHALL win; the pop is irrelevant and the response is discarded.
REQ-025 Consecutive redirects SHALL each take effect; only the last redirect_pc is fetched.
REQ-026 Default latency: a response written in cycle N SHALL appear on instr/instr_valid in cycle N+1.

Reset
REQ-027 While reset is low: fetch PC = RESET_PC, occupancy, outstanding, stale and pointers = 0, ireq_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-028 First request SHALL be issued in the first cycle after reset deasserts, with ireq_addr = RESET_PC.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight state immediately; responses arriving after release SHALL be treated per reset-state rules (outstanding = 0).

Configuration
REQ-030 Macro IFQ_BYPASS_EN defined: when the queue is empty and a non-stale response arrives, it SHALL drive instr/instr_pc/instr_valid combinationally in the same cycle, and is not enqueued if popped that cycle.
REQ-031 IFQ_BYPASS_EN undefined: no combinational path from iresp_* to instr_*; latency per REQ-026.

Verification
REQ-032 Reset release, ireq_ready=1, 1-cycle response latency, instr_ready=1 -> ireq_addr 0x0,0x4,0x8...; instr_pc follows in order, one instr per cycle after fill.
REQ-033 instr_ready=0 with DEPTH=4 -> exactly 4 requests accepted, then ireq_valid=0; releasing instr_ready resumes fetch at 0x10.
REQ-034 Redirect to 0x0000_0103 with 2 fetches outstanding -> next ireq_addr 0x0000_0100, next 2 responses dropped, first instr_pc 0x100.
REQ-035 Redirect in same cycle as iresp_valid and pop -> queue empty next cycle, response dropped, stale = remaining outstanding.
REQ-036 Fetch PC at 0xFFFF_FFFC accepted -> next ireq_addr 0x0000_0000.
REQ-037 With IFQ_BYPASS_EN, empty queue, response 0x0000_0013 at cycle N -> instr=0x0000_0013, instr_valid=1 in cycle N; without it, in cycle N+1.
